// File: rtl/qc_ldpc_pkg.sv
// Shared types, constants and shift table for the QC-LDPC stream encoder.
// Shift values scale from the Z=81 base table down to the selected Z.
package qc_ldpc_pkg;

    localparam int Z_27 = 27;
    localparam int Z_54 = 54;
    localparam int Z_81 = 81;

    localparam int SHW = 7;
    localparam logic [SHW-1:0] SH_NULL = 7'h7F;

    localparam int BASE_ROWS = 4;
    localparam int BASE_COLS = 20;

    typedef enum logic [1:0] {
        ZSEL_27  = 2'd0,
        ZSEL_54  = 2'd1,
        ZSEL_81  = 2'd2,
        ZSEL_BAD = 2'd3
    } zsel_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_DRAIN
    } enc_state_e;

    localparam logic [SHW-1:0] N = SH_NULL;

    localparam logic [SHW-1:0] SHIFT_BASE [BASE_ROWS][BASE_COLS] = '{
        '{7'd13, 7'd48, 7'd80, 7'd66, 7'd4,  7'd74, 7'd7,  7'd30, 7'd76, 7'd52,
          7'd37, 7'd60, N,     7'd49, 7'd73, 7'd31, 7'd74, 7'd73, 7'd23, N},
        '{7'd69, 7'd63, 7'd74, 7'd56, 7'd64, 7'd77, 7'd57, 7'd65, 7'd6,  7'd16,
          7'd51, N,     7'd64, N,     7'd68, 7'd9,  7'd48, 7'd62, 7'd54, 7'd27},
        '{7'd51, 7'd15, 7'd0,  7'd80, 7'd24, 7'd25, 7'd42, 7'd54, 7'd44, 7'd71,
          7'd71, 7'd9,  7'd67, 7'd35, N,     7'd58, N,     7'd29, N,     7'd53},
        '{7'd16, 7'd29, 7'd36, 7'd41, 7'd44, 7'd56, 7'd59, 7'd37, 7'd50, 7'd24,
          N,     7'd65, 7'd4,  7'd65, 7'd52, N,     7'd4,  N,     7'd73, 7'd52}
    };

    // Illegal select falls back to the full 81-bit circulant.
    function automatic int z_of(input logic [1:0] zs);
        int z;
        case (zs)
            ZSEL_27: z = Z_27;
            ZSEL_54: z = Z_54;
            default: z = Z_81;
        endcase
        return z;
    endfunction

    // floor(base*Z/81) keeps every non-null shift strictly below Z.
    function automatic logic [SHW-1:0] shift_of(input logic [1:0] zs,
                                                input int p,
                                                input int i);
        logic [SHW-1:0] b;
        logic [SHW-1:0] s;
        b = SHIFT_BASE[p % BASE_ROWS][i % BASE_COLS];
        if (b == SH_NULL)
            s = SH_NULL;
        else
            s = SHW'((int'(b) * z_of(zs)) / Z_81);
        return s;
    endfunction

endpackage

// File: rtl/qc_ldpc_shift_rom.sv
// Combinational shift-entry lookup: one entry per parity row
// for the given circulant size and info column.
module qc_ldpc_shift_rom
    import qc_ldpc_pkg::*;
#(
    parameter int NUM_INFO_BLKS   = 20,
    parameter int NUM_PARITY_BLKS = 4,
    parameter int CW = (NUM_INFO_BLKS > 1) ? $clog2(NUM_INFO_BLKS) : 1
)(
    input  logic [1:0]                            i_zsel,
    input  logic [CW-1:0]                         i_col,
    output logic [NUM_PARITY_BLKS-1:0][SHW-1:0]   o_shift
);

    always_comb begin
        o_shift = '0;
        for (int p = 0; p < NUM_PARITY_BLKS; p++)
            o_shift[p] = shift_of(i_zsel, p, int'(i_col));
    end

endmodule

// File: rtl/qc_ldpc_stream_encoder.sv
// Streaming QC-LDPC parity accumulator: XORs rotated info blocks into
// NUM_PARITY_BLKS accumulators, then drains them over a valid/ready port.
module qc_ldpc_stream_encoder
    import qc_ldpc_pkg::*;
#(
    parameter int ZMAX            = 81,
    parameter int NUM_INFO_BLKS   = 20,
    parameter int NUM_PARITY_BLKS = 4
)(
    input  logic                                clk,
    input  logic                                rst,
    input  logic [1:0]                          z_sel,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [ZMAX-1:0]                     in_data,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [ZMAX-1:0]                     out_data,
    output logic [$clog2(NUM_PARITY_BLKS)-1:0]  out_idx,
    output logic                                out_last,
    output logic                                err_zsel
);

    localparam int CW = (NUM_INFO_BLKS > 1) ? $clog2(NUM_INFO_BLKS) : 1;
    localparam int IW = $clog2(NUM_PARITY_BLKS);

    enc_state_e                               r_state;
    logic [1:0]                               r_zs;
    logic [CW-1:0]                            r_cnt;
    logic [IW-1:0]                            r_oidx;
    logic [NUM_PARITY_BLKS-1:0][ZMAX-1:0]     r_acc;
    logic                                     r_err;

    logic                                     w_in_xfer;
    logic                                     w_out_xfer;
    logic                                     w_first;
    logic [1:0]                               w_zs;
    int                                       w_z;
    logic [NUM_PARITY_BLKS-1:0][SHW-1:0]      w_shift;
    logic [NUM_PARITY_BLKS-1:0][ZMAX-1:0]     w_upd;

    function automatic logic [ZMAX-1:0] rotl(input logic [ZMAX-1:0] d,
                                             input int z,
                                             input logic [SHW-1:0] s);
        logic [ZMAX-1:0] m;
        logic [ZMAX-1:0] w;
        m = '1;
        m = m >> (ZMAX - z);
        w = d & m;
        return ((w << s) | (w >> (z - int'(s)))) & m;
    endfunction

    assign in_ready   = (r_state != ST_DRAIN);
    assign out_valid  = (r_state == ST_DRAIN);
    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = out_valid && out_ready;
    assign w_first    = w_in_xfer && (r_state == ST_IDLE);

    // The first beat uses the live select; later beats use the latched one.
    assign w_zs = (r_state != ST_IDLE) ? r_zs :
                  (z_sel == ZSEL_BAD)  ? ZSEL_81 : z_sel;

    qc_ldpc_shift_rom #(
        .NUM_INFO_BLKS   (NUM_INFO_BLKS),
        .NUM_PARITY_BLKS (NUM_PARITY_BLKS),
        .CW              (CW)
    ) u_rom (
        .i_zsel  (w_zs),
        .i_col   (r_cnt),
        .o_shift (w_shift)
    );

    always_comb begin
        w_z   = z_of(w_zs);
        w_upd = '0;
        for (int p = 0; p < NUM_PARITY_BLKS; p++)
            if (w_shift[p] != SH_NULL)
                w_upd[p] = rotl(in_data, w_z, w_shift[p]);
    end

    assign out_data = out_valid ? r_acc[r_oidx] : '0;
    assign out_idx  = r_oidx;
    assign out_last = out_valid && (r_oidx == IW'(NUM_PARITY_BLKS - 1));
    assign err_zsel = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_zs    <= ZSEL_27;
            r_cnt   <= '0;
            r_oidx  <= '0;
            r_acc   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= w_first && (z_sel == ZSEL_BAD);
            if (w_in_xfer) begin
                for (int p = 0; p < NUM_PARITY_BLKS; p++)
                    r_acc[p] <= (w_first ? '0 : r_acc[p]) ^ w_upd[p];
                if (w_first)
                    r_zs <= w_zs;
                if (r_cnt == CW'(NUM_INFO_BLKS - 1)) begin
                    r_cnt   <= '0;
                    r_oidx  <= '0;
                    r_state <= ST_DRAIN;
                end else begin
                    r_cnt   <= r_cnt + 1'b1;
                    r_state <= ST_ACCUM;
                end
            end
            if (w_out_xfer) begin
                if (r_oidx == IW'(NUM_PARITY_BLKS - 1)) begin
                    r_oidx  <= '0;
                    r_state <= ST_IDLE;
                end else begin
                    r_oidx <= r_oidx + 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/qc_ldpc_stream_encoder.md
QC_LDPC_STREAM_ENCODER -- requirements
Module: qc_ldpc_stream_encoder

Interface
REQ-001 Parameter ZMAX, default 81, largest circulant size and datapath width.
REQ-002 Parameter NUM_INFO_BLKS, default 20, info blocks per frame.
REQ-003 Parameter NUM_PARITY_BLKS, default 4, parity blocks per frame.
REQ-004 Port clk  input  1  sole clock, all logic on rising edge.
REQ-005 Port rst  input  1  reset, synchronous, active-high.
REQ-006 Port z_sel  input  2  circulant size select: 0=27, 1=54, 2=81, 3=illegal; sampled on first accepted beat of a frame.
REQ-007 Port in_valid  input  1  info block present on in_data.
REQ-008 Port in_ready  output  1  encoder accepts an info block this cycle.
REQ-009 Port in_data  input  ZMAX  info block, bits [Z-1:0] meaningful.
REQ-010 Port out_valid  output  1  parity block present on out_data.
REQ-011 Port out_ready  input  1  downstream accepts parity block.
REQ-012 Port out_data  output  ZMAX  parity block, bits >= Z driven 0.
REQ-013 Port out_idx  output  clog2(NUM_PARITY_BLKS)  index of parity block on out_data.
REQ-014 Port out_last  output  1  high with final parity block of frame.
REQ-015 Port err_zsel  output  1  one-cycle pulse when a frame starts with z_sel=3.

Function
REQ-016 Transfer occurs on a cycle where valid and ready are both high; no other cycle changes frame state.
REQ-017 FSM states IDLE, ACCUM, DRAIN; IDLE->ACCUM on first input transfer; ACCUM->DRAIN on transfer of block NUM_INFO_BLKS-1; DRAIN->IDLE on output transfer with out_last=1.
REQ-018 in_ready SHALL be 1 in IDLE and ACCUM, 0 in DRAIN.
REQ-019 First-beat transfer latches Z; z_sel=3 latches Z=81 and pulses err_zsel the following cycle.
REQ-020 z_sel changes after the first beat SHALL have no effect on the current frame.
REQ-021 Info block counter i runs 0..NUM_INFO_BLKS-1, increments per input transfer, clears on frame end.
REQ-022 On transfer of block i, every accumulator p SHALL update acc[p] ^= rotl_Z(in_data[Z-1:0], S[p][i]) if S[p][i] is not the null entry, else remain unchanged; all NUM_PARITY_BLKS updates in the same cycle.
REQ-023 rotl_Z is cyclic left rotation within Z bits; shift 0 is identity; in_data bits >= Z SHALL be ignored.
REQ-024 Accumulators clear to 0 in IDLE on first-beat transfer (block 0 result overwrites, not XORs, prior contents).
REQ-025 out_valid SHALL rise the cycle after the last info transfer; parity blocks emitted in order p=0..NUM_PARITY_BLKS-1, one per output transfer.
REQ-026 out_data/out_idx/out_last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-027 in_valid gaps in ACCUM SHALL stall the counter without altering accumulators.
REQ-028 Minimum frame period: NUM_INFO_BLKS + NUM_PARITY_BLKS cycles; next frame first beat accepted the cycle after out_last transfer.

Reset
REQ-029 rst=1 at any clock edge SHALL force IDLE, counters 0, accumulators 0, in_ready=1, out_valid=0, out_data=0, out_idx=0, out_last=0, err_zsel=0.
REQ-030 Reset mid-frame discards the partial frame with no output emitted.

Structure
REQ-031 Shared package qc_ldpc_pkg SHALL hold z_sel encoding, Z constants 27/54/81, shift entry width 7, null-entry sentinel 7'h7F, and FSM state enum.
REQ-032 Sub-module qc_ldpc_shift_rom SHALL be combinational: inputs Z select and column i, output NUM_PARITY_BLKS shift entries, all non-null values < Z.

Verification
REQ-033 Z=27, 20 all-zero blocks, out_ready=1 -> four parity blocks all 0, out_idx 0..3, out_last only on idx 3, out_valid one cycle after 20th transfer.
REQ-034 Z=54, block 0 = 54'h1, others 0 -> parity p = 1<<S[p][0] (0 if null), matched against package-driven reference model.
REQ-035 Z=81, random data, out_ready low 5 cycles at idx 1 -> out_data/out_idx held constant, no block lost or duplicated.
REQ-036 rst asserted after 7 transfers -> next cycle in_ready=1, out_valid=0; following full random frame matches model.
REQ-037 z_sel=3 on first beat -> err_zsel=1 exactly one cycle later, frame encoded as Z=81.
REQ-038 Z=27 with in_data[80:27] random and random in_valid gaps -> parity identical to clean-input run, out_data[80:27]=0.
